// File: rtl/thread_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// thread_fetch_unit_pkg
// Shared definitions for the barrel-core instruction-fetch stage.
//   TID_W         : thread-id width of the fetch-entry struct; sized for the
//                   largest supported thread count so one struct serves all
//                   configurations
//   PC_W          : PC width carried in a fetch entry
//   INSTR_W       : instruction width
//   NOP_INSTR     : addi x0,x0,0, shown on the decode interface when idle
//   fetch_entry_t : {live, tid, pc} record used by request/skid/output stages
//   squash_entry  : clears live when a redirect targets the entry's thread
// ----------------------------------------------------------------------------
package thread_fetch_unit_pkg;

    localparam int MAX_THREADS = 8;
    localparam int TID_W       = $clog2(MAX_THREADS);
    localparam int PC_W        = 64;
    localparam int INSTR_W     = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic             live;
        logic [TID_W-1:0] tid;
        logic [PC_W-1:0]  pc;
    } fetch_entry_t;

    // An entry belonging to the redirected thread is wrong-path work.
    function automatic fetch_entry_t squash_entry(
        input fetch_entry_t     e,
        input logic             redirect,
        input logic [TID_W-1:0] redirect_tid
    );
        squash_entry = e;
        if (redirect && (e.tid == redirect_tid)) begin
            squash_entry.live = 1'b0;
        end
    endfunction

endpackage

// File: rtl/thread_fetch_unit_arbiter.sv
// ----------------------------------------------------------------------------
// rr_thread_arbiter
// Combinational round-robin pick: the first enabled thread strictly after the
// pointer, wrapping around, so the pointer's own thread is considered last.
//   enable    : per-thread request mask
//   pointer   : thread granted most recently
//   grant     : index of the chosen thread (equals pointer when none)
//   any_grant : at least one thread is enabled
// NUM_THREADS must be a power of two so the index arithmetic wraps naturally.
// ----------------------------------------------------------------------------
module rr_thread_arbiter #(
    parameter int NUM_THREADS = 4
) (
    input  logic [NUM_THREADS-1:0]         enable,
    input  logic [$clog2(NUM_THREADS)-1:0] pointer,
    output logic [$clog2(NUM_THREADS)-1:0] grant,
    output logic                           any_grant
);

    localparam int TID_BITS = $clog2(NUM_THREADS);

    logic [TID_BITS-1:0] idx;

    // Walk pointer+1 .. pointer+NUM_THREADS; the last step lands back on the
    // pointer itself, giving it lowest priority.
    always_comb begin
        grant     = pointer;
        any_grant = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            idx = pointer + TID_BITS'(i);
            if (!any_grant && enable[idx]) begin
                grant     = idx;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_fetch_unit.sv
// ----------------------------------------------------------------------------
// thread_fetch_unit
// Instruction-fetch stage of the barrel core. Keeps one PC per hardware
// thread, picks an enabled thread round-robin each cycle, reads instruction
// memory with 1-cycle latency and hands {instr, pc, tid, valid} to decode.
// Taken-branch redirects squash wrong-path work of the redirected thread and
// a 1-entry skid buffer absorbs the response that is in flight when decode
// stalls.
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   thread_en       : per-thread fetch enable
//   stall           : decode cannot accept; outputs hold, no new selects
//   br_taken/br_tid/br_target : redirect from execute
//   imem_en/imem_addr         : instruction memory read request
//   imem_rdata      : instruction, valid the cycle after imem_en
//   if_valid/if_instr/if_pc/if_tid : decode interface
//   perf_fetch_cnt  : per-thread delivered-instruction counters
//                     (only when FETCH_PERF_CNT_EN is defined)
//
// Build option: `define FETCH_PERF_CNT_EN adds perf_fetch_cnt.
// ----------------------------------------------------------------------------
module thread_fetch_unit #(
    parameter int              NUM_THREADS = 4,
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [XLEN-1:0] PC_STRIDE   = XLEN'(64'h400)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_THREADS-1:0]         thread_en,
    input  logic                           stall,
    input  logic                           br_taken,
    input  logic [$clog2(NUM_THREADS)-1:0] br_tid,
    input  logic [XLEN-1:0]                br_target,
    output logic                           imem_en,
    output logic [XLEN-1:0]                imem_addr,
    input  logic [31:0]                    imem_rdata,
    output logic                           if_valid,
    output logic [31:0]                    if_instr,
    output logic [XLEN-1:0]                if_pc,
    output logic [$clog2(NUM_THREADS)-1:0] if_tid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [NUM_THREADS*32-1:0]      perf_fetch_cnt
`endif
);

    import thread_fetch_unit_pkg::*;

    localparam int TID_BITS = $clog2(NUM_THREADS);

    // Architectural and pipeline state
    logic [XLEN-1:0]     pc_q [NUM_THREADS];
    logic [TID_BITS-1:0] rr_ptr_q;
    fetch_entry_t        req_q;
    fetch_entry_t        skid_q;
    logic [INSTR_W-1:0]  skid_instr_q;
    fetch_entry_t        out_q;
    logic [INSTR_W-1:0]  out_instr_q;

    // Select-stage signals
    logic [TID_BITS-1:0] sel;
    logic                sel_any;
    logic                issue;
    logic                sel_redirect;
    logic [XLEN-1:0]     fetch_pc;
    logic [TID_W-1:0]    br_tid_w;

    // Entries as they look after this cycle's redirect squash
    fetch_entry_t        resp_sq;
    fetch_entry_t        skid_sq;
    fetch_entry_t        out_sq;

    rr_thread_arbiter #(
        .NUM_THREADS (NUM_THREADS)
    ) u_arbiter (
        .enable    (thread_en),
        .pointer   (rr_ptr_q),
        .grant     (sel),
        .any_grant (sel_any)
    );

    // Select: a redirect to the thread being picked this very cycle already
    // supplies the correct-path address, so the fetch uses br_target directly.
    always_comb begin
        br_tid_w     = TID_W'(br_tid);
        issue        = rst_n && !stall && sel_any;
        sel_redirect = br_taken && (br_tid == sel);
        fetch_pc     = sel_redirect ? br_target : pc_q[sel];
        imem_en      = issue;
        imem_addr    = fetch_pc;
    end

    // The response pairs the request-stage record with this cycle's rdata.
    always_comb begin
        resp_sq = squash_entry(req_q,  br_taken, br_tid_w);
        skid_sq = squash_entry(skid_q, br_taken, br_tid_w);
        out_sq  = squash_entry(out_q,  br_taken, br_tid_w);
    end

    // PC file and round-robin pointer. A redirect always wins over the
    // sequential increment; if the redirected thread is also being fetched
    // now, its next PC is the target plus one instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= RESET_PC + XLEN'(t) * PC_STRIDE;
            end
            rr_ptr_q <= TID_BITS'(NUM_THREADS - 1);
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (br_taken && (br_tid == TID_BITS'(t))) begin
                    pc_q[t] <= (issue && (sel == TID_BITS'(t)))
                             ? br_target + XLEN'(4)
                             : br_target;
                end else if (issue && (sel == TID_BITS'(t))) begin
                    pc_q[t] <= pc_q[t] + XLEN'(4);
                end
            end
            if (issue) begin
                rr_ptr_q <= sel;
            end
        end
    end

    // Request, skid and output stages. While stalled the outputs hold and the
    // single in-flight response parks in the skid buffer; select stops in the
    // same cycle, so nothing else can arrive behind it. When the stall drops
    // the skid entry drains first; the request stage is empty at that point
    // because no select happened during the stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q        <= '0;
            skid_q       <= '0;
            skid_instr_q <= NOP_INSTR;
            out_q        <= '0;
            out_instr_q  <= NOP_INSTR;
        end else begin
            req_q.live <= issue;
            req_q.tid  <= TID_W'(sel);
            req_q.pc   <= PC_W'(fetch_pc);

            if (stall) begin
                out_q <= out_sq;
                if (!out_sq.live) begin
                    out_instr_q <= NOP_INSTR;
                end
                if (resp_sq.live) begin
                    skid_q       <= resp_sq;
                    skid_instr_q <= imem_rdata;
                end else begin
                    skid_q <= skid_sq;
                end
            end else if (skid_q.live) begin
                out_q       <= skid_sq;
                out_instr_q <= skid_sq.live ? skid_instr_q : NOP_INSTR;
                skid_q.live <= 1'b0;
            end else begin
                out_q       <= resp_sq;
                out_instr_q <= resp_sq.live ? imem_rdata : NOP_INSTR;
            end
        end
    end

    always_comb begin
        if_valid = out_q.live;
        if_instr = out_instr_q;
        if_pc    = out_q.pc[XLEN-1:0];
        if_tid   = out_q.tid[TID_BITS-1:0];
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_cnt_q [NUM_THREADS];

    // An instruction counts when decode actually takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                perf_cnt_q[t] <= '0;
            end
        end else if (out_q.live && !stall) begin
            perf_cnt_q[if_tid] <= perf_cnt_q[if_tid] + 32'd1;
        end
    end

    always_comb begin
        perf_fetch_cnt = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            perf_fetch_cnt[t*32 +: 32] = perf_cnt_q[t];
        end
    end
`endif

endmodule

// File: tb/tb_thread_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_thread_fetch_unit
// Directed bench for thread_fetch_unit (4 threads, 64-bit PCs). The
// instruction memory model returns the low 32 address bits one cycle after
// imem_en, so every delivered if_instr must equal its own if_pc[31:0].
// Each scenario starts from a fresh reset; cycle k is the k-th cycle after
// rst_n rises, and outputs are observed 1ns after each rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_thread_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  thread_en;
    logic        stall;
    logic        br_taken;
    logic [1:0]  br_tid;
    logic [63:0] br_target;
    logic        imem_en;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic [1:0]  if_tid;
`ifdef FETCH_PERF_CNT_EN
    logic [127:0] perf_fetch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous instruction memory: data = address, one cycle later.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr[31:0];
    end

    thread_fetch_unit #(
        .NUM_THREADS (4),
        .XLEN        (64),
        .RESET_PC    (64'h0),
        .PC_STRIDE   (64'h400)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .thread_en  (thread_en),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_tid     (br_tid),
        .br_target  (br_target),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_tid     (if_tid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles, then release; returns inside cycle 0.
    task automatic do_reset(input logic [3:0] en);
        rst_n     = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_tid    = 2'd0;
        br_target = 64'h0;
        thread_en = en;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [1:0]  exp_tid [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [63:0] exp_pc  [5] = '{64'h0, 64'h400, 64'h800, 64'hC00, 64'h4};
        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_tid = 2'd0;
        br_target = 64'h0; thread_en = 4'b1111;
        tick();
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", if_valid); end
        checks++; if (if_instr !== NOP) begin errors++; $display("[TB] FAIL reset_instr: got %h want %h", if_instr, NOP); end
        checks++; if (if_pc !== 64'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h want 0", if_pc); end
        checks++; if (if_tid !== 2'd0) begin errors++; $display("[TB] FAIL reset_tid: got %0d want 0", if_tid); end
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_imem_en: got %b want 0", imem_en); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b1) begin errors++; $display("[TB] FAIL first_select_en: got %b want 1", imem_en); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL first_select_addr: got %h want 0", imem_addr); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL first_valid_early: got %b want 0", if_valid); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_valid[%0d]: got %b want 1", k, if_valid); end
            checks++; if (if_tid !== exp_tid[k]) begin errors++; $display("[TB] FAIL rr_tid[%0d]: got %0d want %0d", k, if_tid, exp_tid[k]); end
            checks++; if (if_pc !== exp_pc[k]) begin errors++; $display("[TB] FAIL rr_pc[%0d]: got %h want %h", k, if_pc, exp_pc[k]); end
            checks++; if (if_instr !== exp_pc[k][31:0]) begin errors++; $display("[TB] FAIL rr_instr[%0d]: got %h want %h", k, if_instr, exp_pc[k][31:0]); end
        end
    endtask

    task automatic test_thread_enable();
        logic [1:0]  exp_tid [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
        logic [63:0] exp_pc  [4] = '{64'h0, 64'h800, 64'h4, 64'h804};
        do_reset(4'b0101);
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL en_valid[%0d]: got %b want 1", k, if_valid); end
            checks++; if (if_tid !== exp_tid[k]) begin errors++; $display("[TB] FAIL en_tid[%0d]: got %0d want %0d", k, if_tid, exp_tid[k]); end
            checks++; if (if_pc !== exp_pc[k]) begin errors++; $display("[TB] FAIL en_pc[%0d]: got %h want %h", k, if_pc, exp_pc[k]); end
        end
        thread_en = 4'b0000;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL none_enabled_imem_en: got %b want 0", imem_en); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 64'h8) begin errors++; $display("[TB] FAIL inflight_delivery: valid %b pc %h want 1 8", if_valid, if_pc); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL none_enabled_valid: got %b want 0", if_valid); end
        checks++; if (if_instr !== NOP) begin errors++; $display("[TB] FAIL none_enabled_instr: got %h want %h", if_instr, NOP); end
        tick();
        checks++; if (imem_en !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL none_enabled_idle: en %b valid %b want 0 0", imem_en, if_valid); end
    endtask

    task automatic test_stall();
        logic [1:0]  exp_tid [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        logic [63:0] exp_pc  [4] = '{64'h800, 64'hC00, 64'h4, 64'h404};
        do_reset(4'b1111);
        tick();
        tick();
        tick();
        checks++; if (if_tid !== 2'd1 || if_pc !== 64'h400) begin errors++; $display("[TB] FAIL pre_stall: tid %0d pc %h want 1 400", if_tid, if_pc); end
        stall = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL stall_imem_en: got %b want 0", imem_en); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (if_valid !== 1'b1 || if_tid !== 2'd1 || if_pc !== 64'h400 || if_instr !== 32'h400) begin
                errors++; $display("[TB] FAIL stall_hold[%0d]: valid %b tid %0d pc %h instr %h want 1 1 400 400", k, if_valid, if_tid, if_pc, if_instr);
            end
        end
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid[%0d]: got %b want 1", k, if_valid); end
            checks++; if (if_tid !== exp_tid[k]) begin errors++; $display("[TB] FAIL drain_tid[%0d]: got %0d want %0d", k, if_tid, exp_tid[k]); end
            checks++; if (if_pc !== exp_pc[k] || if_instr !== exp_pc[k][31:0]) begin errors++; $display("[TB] FAIL drain_pc[%0d]: pc %h instr %h want %h", k, if_pc, if_instr, exp_pc[k]); end
        end
    endtask

    task automatic test_redirect_squash();
        logic [1:0]  exp_tid [8] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [63:0] exp_pc  [8] = '{64'h800, 64'hC00, 64'h4, 64'h2000, 64'h804, 64'hC04, 64'h8, 64'h2004};
        do_reset(4'b1111);
        tick();
        tick();
        br_taken = 1'b1; br_tid = 2'd1; br_target = 64'h2000;
        tick();
        br_taken = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL squash_valid: got %b want 0", if_valid); end
        checks++; if (if_instr !== NOP) begin errors++; $display("[TB] FAIL squash_instr: got %h want %h", if_instr, NOP); end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (if_valid !== 1'b1 || if_tid !== exp_tid[k]) begin errors++; $display("[TB] FAIL redir_tid[%0d]: valid %b tid %0d want 1 %0d", k, if_valid, if_tid, exp_tid[k]); end
            checks++; if (if_pc !== exp_pc[k] || if_instr !== exp_pc[k][31:0]) begin errors++; $display("[TB] FAIL redir_pc[%0d]: pc %h instr %h want %h", k, if_pc, if_instr, exp_pc[k]); end
        end
    endtask

    task automatic test_redirect_stall();
        logic [1:0]  exp_tid [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        logic [63:0] exp_pc  [4] = '{64'h800, 64'hC00, 64'h4, 64'h3000};
        do_reset(4'b1111);
        tick();
        tick();
        stall = 1'b1; br_taken = 1'b1; br_tid = 2'd1; br_target = 64'h3000;
        tick();
        stall = 1'b0; br_taken = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_tid !== 2'd0 || if_pc !== 64'h0) begin errors++; $display("[TB] FAIL rs_hold: valid %b tid %0d pc %h want 1 0 0", if_valid, if_tid, if_pc); end
        tick();
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP) begin errors++; $display("[TB] FAIL rs_squash: valid %b instr %h want 0 %h", if_valid, if_instr, NOP); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (if_valid !== 1'b1 || if_tid !== exp_tid[k] || if_pc !== exp_pc[k]) begin
                errors++; $display("[TB] FAIL rs_seq[%0d]: valid %b tid %0d pc %h want 1 %0d %h", k, if_valid, if_tid, if_pc, exp_tid[k], exp_pc[k]);
            end
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset(4'b1111);
        br_taken = 1'b1; br_tid = 2'd0; br_target = 64'h100;
        #1;
        checks++; if (imem_en !== 1'b1 || imem_addr !== 64'h100) begin errors++; $display("[TB] FAIL same_cycle_addr: en %b addr %h want 1 100", imem_en, imem_addr); end
        tick();
        br_taken = 1'b0;
        tick();
        checks++; if (if_valid !== 1'b1 || if_tid !== 2'd0 || if_pc !== 64'h100 || if_instr !== 32'h100) begin
            errors++; $display("[TB] FAIL same_cycle_out: valid %b tid %0d pc %h instr %h want 1 0 100 100", if_valid, if_tid, if_pc, if_instr);
        end
        tick();
        tick();
        checks++; if (imem_en !== 1'b1 || imem_addr !== 64'h104) begin errors++; $display("[TB] FAIL same_cycle_next_addr: en %b addr %h want 1 104", imem_en, imem_addr); end
        tick();
        tick();
        checks++; if (if_valid !== 1'b1 || if_tid !== 2'd0 || if_pc !== 64'h104) begin errors++; $display("[TB] FAIL same_cycle_next_out: valid %b tid %0d pc %h want 1 0 104", if_valid, if_tid, if_pc); end
    endtask

    task automatic test_reset_midstream();
        do_reset(4'b1111);
        tick();
        tick();
        tick();
        stall = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 64'h0 || if_tid !== 2'd0) begin
            errors++; $display("[TB] FAIL midreset_out: valid %b instr %h pc %h tid %0d want reset values", if_valid, if_instr, if_pc, if_tid);
        end
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL midreset_imem_en: got %b want 0", imem_en); end
        rst_n = 1'b1; stall = 1'b0;
        #1;
        checks++; if (imem_en !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL midreset_pc_restore: en %b addr %h want 1 0", imem_en, imem_addr); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_skid_discard: got %b want 0", if_valid); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_tid !== 2'd0 || if_pc !== 64'h0) begin errors++; $display("[TB] FAIL midreset_first: valid %b tid %0d pc %h want 1 0 0", if_valid, if_tid, if_pc); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_tid !== 2'd1 || if_pc !== 64'h400) begin errors++; $display("[TB] FAIL midreset_second: valid %b tid %0d pc %h want 1 1 400", if_valid, if_tid, if_pc); end
    endtask

    initial begin
        test_reset();
        test_thread_enable();
        test_stall();
        test_redirect_squash();
        test_redirect_stall();
        test_redirect_same_cycle();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/thread_fetch_unit.md
Name: thread_fetch_unit

Overview:
- Instruction-fetch stage of the 4-thread barrel core; feeds the decode/control stage directly.
- Holds one PC per hardware thread and picks an enabled thread round-robin each cycle.
- Issues a 1-cycle-latency synchronous read to instruction memory and delivers {instr, pc, tid, valid} to decode.
- Applies taken-branch redirects from execute, squashes wrong-path fetches of the redirected thread, and absorbs decode stalls with a 1-entry skid buffer.

Parameters:
- NUM_THREADS, 4, number of hardware threads (power of 2, 2..8)
- XLEN, 64, PC / address width
- RESET_PC, 64'h0, reset PC of thread 0
- PC_STRIDE, 64'h400, reset PC of thread t = RESET_PC + t*PC_STRIDE

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- thread_en  in  NUM_THREADS  per-thread fetch enable
- stall  in  1  decode cannot accept; hold outputs
- br_taken  in  1  taken-branch redirect strobe from execute
- br_tid  in  log2(NUM_THREADS)  thread being redirected
- br_target  in  XLEN  redirect PC
- imem_en  out  1  imem read strobe
- imem_addr  out  XLEN  imem read address (PC)
- imem_rdata  in  32  instruction, valid the cycle after imem_en
- if_valid  out  1  if_instr/if_pc/if_tid valid
- if_instr  out  32  instruction to decode; NOP when !if_valid
- if_pc  out  XLEN  PC of if_instr
- if_tid  out  log2(NUM_THREADS)  thread of if_instr

Behaviour:
- Clock and reset: one clock (clk); synchronous active-low reset (rst_n).
- Reset values:
  - pc[t] = RESET_PC + t*PC_STRIDE; rr pointer = NUM_THREADS-1, so thread 0 is picked first.
  - imem_en=0; if_valid=0; if_instr=32'h00000013 (addi x0,x0,0); if_pc=0; if_tid=0.
  - Request and skid stages empty.
- Reset takes priority over every other input; any in-flight read is discarded.
- Select (cycle N), only when !stall:
  - Pick the first enabled thread after the rr pointer, with wrap-around.
  - If none is enabled, imem_en=0 and nothing is issued.
  - Otherwise imem_en=1, imem_addr=pc[sel], pc[sel]+=4 (mod 2^XLEN), rr pointer=sel.
  - The request stage records {pc, tid, live=1}.
- Response (cycle N+1): imem_rdata is paired with the recorded {pc, tid}.
  - !stall: load the output registers (if_valid = live).
  - stall: write into the skid buffer instead.
- Stall behaviour:
  - Outputs hold while stall=1; no new selects.
  - When stall drops, the skid entry drains to the outputs first and select resumes in the same cycle.
  - Skid depth 1 is sufficient because select stops the cycle stall is seen.
- Redirect (br_taken=1, tid b):
  - pc[b] <= br_target.
  - Same-cycle select of b uses br_target as address, and pc[b] <= br_target+4.
  - Same cycle, every request/skid/output entry with tid==b is squashed (live/valid cleared). A squashed output shows if_valid=0, if_instr=NOP.
- Redirect with stall=1: PC update and squash still occur.
- Thread disable mid-flight: the disabled thread's already-issued instructions still deliver; that thread is not selected again and its PC is held.
- Misaligned br_target (bits[1:0]≠0): used unchanged; no trap.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds output perf_fetch_cnt [NUM_THREADS*32-1:0].
  - One 32-bit wrapping counter per thread, incremented when that thread's instruction leaves with if_valid=1 and !stall.
  - Cleared by rst_n.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - TID_W = $clog2(NUM_THREADS)
  - NOP_INSTR = 32'h00000013
  - INSTR_W = 32
  - fetch-entry struct {live, tid, pc}
- Sub-module rr_thread_arbiter (inputs: enable mask, pointer; outputs: grant index, any_grant).
- PC file, request stage and skid buffer stay in thread_fetch_unit.

Test Plan:
- Reset, thread_en=4'b1111, imem returns addr[31:0] → if_tid sequence 0,1,2,3,0; if_pc 0x0,0x400,0x800,0xC00,0x4; first if_valid two cycles after rst_n rises.
- thread_en=4'b0101 → only tids 0,2 alternate; thread_en=0 → imem_en=0, if_valid=0, if_instr=0x00000013.
- stall held 3 cycles after tid1 output → if_* frozen; after release, the skidded tid2 appears next, then tid3; no instruction lost or duplicated.
- br_taken, br_tid=1, br_target=0x2000 while tid1 is in the request stage → that entry leaves with if_valid=0; next tid1 fetch has if_pc=0x2000, then 0x2004.
- Redirect same cycle tid0 is selected, target 0x100 → imem_addr=0x100, following tid0 fetch 0x104.
- rst_n low mid-stream with a skid entry held → next cycle all outputs at reset values, PCs restored.
